// File: rtl/beep_tone.sv
// rtl/beep_tone.sv - programmable tone/duration beeper on the Z80 I/O bus
module beep_tone #(
    parameter logic [7:0] PORT_BASE    = 8'hD2,
    parameter int         PRESCALE     = 16,
    parameter int         DUR_PRESCALE = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq,
    input  logic       wr,
    input  logic [7:0] a07,
    input  logic [7:0] data,
    output logic       spk,
    output logic       busy
);

    localparam int                TP_W     = $clog2(PRESCALE);
    localparam int                DP_W     = $clog2(DUR_PRESCALE);
    localparam logic [TP_W-1:0]   TP_MAX   = TP_W'(PRESCALE - 1);
    localparam logic [DP_W-1:0]   DP_MAX   = DP_W'(DUR_PRESCALE - 1);
    localparam logic [7:0]        DUR_PORT = PORT_BASE + 8'd1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic            r_iorq_s1, r_iorq_s2;
    logic            r_wr_s1, r_wr_s2;
    logic            r_wact_d;
    logic [1:0]      r_fill;

    state_t          r_state;
    logic [7:0]      r_period;
    logic [7:0]      r_half;
    logic [7:0]      r_dcnt;
    logic [TP_W-1:0] r_tpre;
    logic [DP_W-1:0] r_dpre;
    logic            r_spk;
    logic            r_busy;

    logic            w_wact;
    logic            w_strobe;
    logic            w_wr_period;
    logic            w_wr_dur;
    logic            w_tp_wrap;
    logic            w_dp_wrap;
    logic            w_expire;

    // Write is active only once both synchronised strobes are low.
    // r_wact_d is held high until the synchronisers have refilled after reset,
    // so a bus write already in progress at reset release never strobes.
    assign w_wact      = ~r_iorq_s2 & ~r_wr_s2;
    assign w_strobe    = w_wact & ~r_wact_d;
    assign w_wr_period = w_strobe & (a07 == PORT_BASE);
    assign w_wr_dur    = w_strobe & (a07 == DUR_PORT);
    assign w_tp_wrap   = (r_tpre == TP_MAX);
    assign w_dp_wrap   = (r_dpre == DP_MAX);
    // A duration write in the same cycle as expiry takes precedence.
    assign w_expire    = w_dp_wrap & (r_dcnt == 8'd1) & ~w_wr_dur;

    assign spk  = r_spk;
    assign busy = r_busy;

    // Two-flop synchronisers for the bus strobes and the edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_iorq_s1 <= 1'b1;
            r_iorq_s2 <= 1'b1;
            r_wr_s1   <= 1'b1;
            r_wr_s2   <= 1'b1;
            r_wact_d  <= 1'b1;
            r_fill    <= 2'd0;
        end else begin
            r_iorq_s1 <= iorq;
            r_iorq_s2 <= r_iorq_s1;
            r_wr_s1   <= wr;
            r_wr_s2   <= r_wr_s1;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end else begin
                r_wact_d <= w_wact;
            end
        end
    end

    // Register writes, IDLE/RUN state machine, tone and duration timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_period <= 8'd0;
            r_half   <= 8'd0;
            r_dcnt   <= 8'd0;
            r_tpre   <= '0;
            r_dpre   <= '0;
            r_spk    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_wr_period) begin
                r_period <= data;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_wr_dur && data != 8'd0) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_spk   <= (r_period != 8'd0);
                        r_tpre  <= '0;
                        r_half  <= r_period;
                        r_dcnt  <= data;
                        r_dpre  <= '0;
                    end
                end
                S_RUN: begin
                    // Tone: one half-counter step per prescaler wrap.
                    r_tpre <= w_tp_wrap ? '0 : r_tpre + 1'b1;
                    if (w_tp_wrap) begin
                        if (r_half > 8'd1) begin
                            r_half <= r_half - 8'd1;
                        end else begin
                            r_half <= r_period;
                            if (r_half == 8'd1) begin
                                r_spk <= ~r_spk;
                            end
                        end
                    end
                    if (r_period == 8'd0) begin
                        r_spk <= 1'b0;
                    end
                    // Duration: expire on the wrap where the count leaves 1.
                    r_dpre <= w_dp_wrap ? '0 : r_dpre + 1'b1;
                    if (w_dp_wrap && r_dcnt != 8'd1) begin
                        r_dcnt <= r_dcnt - 8'd1;
                    end
                    if (w_expire) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_spk   <= 1'b0;
                    end
                    // Duration writes while running: abort or retime.
                    if (w_wr_dur) begin
                        if (data == 8'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_spk   <= 1'b0;
                        end else begin
                            r_dcnt <= data;
                            r_dpre <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_spk   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_tone.sv
// tb/tb_beep_tone.sv - scoreboard bench for beep_tone
module tb_beep_tone;

    logic       clk = 1'b0;
    logic       reset;
    logic       iorq;
    logic       wr;
    logic [7:0] a07;
    logic [7:0] data;
    logic       spk;
    logic       busy;

    typedef struct {
        int v;
        int cyc;
    } ev_t;

    ev_t exp_spk[$];
    ev_t exp_busy[$];
    ev_t e_s, e_b;

    int  cyc = 0;
    int  n_total = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;
    logic p_spk, p_busy;

    beep_tone #(
        .PORT_BASE   (8'hD2),
        .PRESCALE    (4),
        .DUR_PRESCALE(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .iorq (iorq),
        .wr   (wr),
        .a07  (a07),
        .data (data),
        .spk  (spk),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_busy(input int v, input int t);
        ev_t e;
        e.v = v;
        e.cyc = t;
        exp_busy.push_back(e);
    endtask

    task automatic push_spk(input int v, input int t);
        ev_t e;
        e.v = v;
        e.cyc = t;
        exp_spk.push_back(e);
    endtask

    // Expected spk edges: high at start, first half, then fixed halves, cut at end.
    task automatic gen_spk(input int start, input int first, input int later, input int endt);
        int v;
        int t;
        v = 1;
        push_spk(1, start);
        t = start + first;
        while (t < endt) begin
            v = 1 - v;
            push_spk(v, t);
            t = t + later;
        end
        if (v == 1) push_spk(0, endt);
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        a07  = a;
        data = d;
        iorq = 1'b0;
        wr   = 1'b0;
        repeat (4) @(negedge clk);
        iorq = 1'b1;
        wr   = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic chk_pending(input string tag);
        chk({tag, "_spk_pending"}, exp_spk.size(), 0);
        chk({tag, "_busy_pending"}, exp_busy.size(), 0);
        exp_spk.delete();
        exp_busy.delete();
    endtask

    // Observed output edges are matched against the expected queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (spk !== p_spk) begin
                if (exp_spk.size() == 0) begin
                    chk("spk_unexpected_edge_cyc", cyc, -1);
                end else begin
                    e_s = exp_spk.pop_front();
                    chk("spk_edge_cyc", cyc, e_s.cyc);
                    chk("spk_edge_val", int'(spk), e_s.v);
                end
                p_spk = spk;
            end
            if (busy !== p_busy) begin
                if (exp_busy.size() == 0) begin
                    chk("busy_unexpected_edge_cyc", cyc, -1);
                end else begin
                    e_b = exp_busy.pop_front();
                    chk("busy_edge_cyc", cyc, e_b.cyc);
                    chk("busy_edge_val", int'(busy), e_b.v);
                end
                p_busy = busy;
            end
        end
    end

    initial begin
        int t0;
        int t1;
        int tp;
        reset = 1'b1;
        iorq  = 1'b1;
        wr    = 1'b1;
        a07   = 8'h00;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_spk", int'(spk), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_spk", int'(spk), 0);
        chk("idle_busy", int'(busy), 0);
        p_spk  = spk;
        p_busy = busy;
        mon_en = 1'b1;

        // Period 0: busy times 5*64, spk silent.
        t0 = cyc;
        push_busy(1, t0 + 3);
        push_busy(0, t0 + 3 + 320);
        bus_wr(8'hD3, 8'd5);
        wait_until(t0 + 100);
        chk("p0_spk_run", int'(spk), 0);
        wait_until(t0 + 330);
        chk_pending("p0");

        // Period 3, duration 2: 12/12 square wave for 128 clk; foreign ports mid-run.
        bus_wr(8'hD2, 8'd3);
        t0 = cyc;
        push_busy(1, t0 + 3);
        push_busy(0, t0 + 131);
        gen_spk(t0 + 3, 12, 12, t0 + 131);
        bus_wr(8'hD3, 8'd2);
        bus_wr(8'hD1, 8'd0);
        bus_wr(8'hD8, 8'd0);
        wait_until(t0 + 140);
        chk_pending("tone");

        // Abort with zero duration after ~50 clk.
        bus_wr(8'hD2, 8'd3);
        t0 = cyc;
        t1 = t0 + 56;
        push_busy(1, t0 + 3);
        push_busy(0, t1 + 3);
        gen_spk(t0 + 3, 12, 12, t1 + 3);
        bus_wr(8'hD3, 8'd10);
        wait_until(t1);
        bus_wr(8'hD3, 8'd0);
        wait_until(t1 + 20);
        chk("abort_busy", int'(busy), 0);
        chk_pending("abort");

        // Period change mid-run: current half stays 12, later halves 4.
        t0 = cyc;
        tp = t0 + 9;
        push_busy(1, t0 + 3);
        push_busy(0, t0 + 259);
        gen_spk(t0 + 3, 12, 4, t0 + 259);
        bus_wr(8'hD3, 8'd4);
        wait_until(tp);
        bus_wr(8'hD2, 8'd1);
        wait_until(t0 + 270);
        chk_pending("reperiod");

        // Duration extend with 20 clk left: 64 more clk, tone phase continuous.
        bus_wr(8'hD2, 8'd3);
        t0 = cyc;
        t1 = t0 + 108;
        push_busy(1, t0 + 3);
        push_busy(0, t1 + 67);
        gen_spk(t0 + 3, 12, 12, t1 + 67);
        bus_wr(8'hD3, 8'd2);
        wait_until(t1);
        bus_wr(8'hD3, 8'd1);
        wait_until(t1 + 80);
        chk_pending("extend");

        // Asynchronous reset while spk is high.
        t0 = cyc;
        push_busy(1, t0 + 3);
        push_busy(0, t0 + 31);
        gen_spk(t0 + 3, 12, 12, t0 + 31);
        bus_wr(8'hD3, 8'd5);
        wait_until(t0 + 30);
        chk("mid_spk_high", int'(spk), 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_spk", int'(spk), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        a07  = 8'hD3;
        data = 8'd5;
        iorq = 1'b0;
        wr   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        iorq = 1'b1;
        wr   = 1'b1;
        repeat (10) @(negedge clk);
        chk("stale_strobe_busy", int'(busy), 0);
        chk_pending("rst");

        // Foreign ports in IDLE.
        bus_wr(8'hD1, 8'd5);
        bus_wr(8'hD8, 8'd5);
        repeat (10) @(negedge clk);
        chk("foreign_busy", int'(busy), 0);
        chk("foreign_spk", int'(spk), 0);

        // Writes work again after reset; period cleared to 0.
        t0 = cyc;
        push_busy(1, t0 + 3);
        push_busy(0, t0 + 67);
        bus_wr(8'hD3, 8'd1);
        wait_until(t0 + 80);
        chk_pending("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
